// File: rtl/pipe_stage_chain.sv
// Elastic DEPTH-stage register chain with global hold and per-stage flush; stats ports under PIPE_STAGE_CHAIN_STATS_EN.
// Latency DEPTH cycles, one transfer per cycle. out_ready=0 ripples back so bubbles collapse; hold freezes every stage.
module pipe_stage_chain #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   input  logic             hold,
   input  logic [DEPTH-1:0] flush_mask
`ifdef PIPE_STAGE_CHAIN_STATS_EN
   ,
   output logic [3:0]       occupancy,
   output logic [15:0]      kill_count
`endif
);

   logic [DEPTH-1:0] stageVld;
   logic [DEPTH-1:0] stageVldNext;
   logic [DEPTH-1:0] move;
   logic [DEPTH:0]   take;
   logic [WIDTH-1:0] stageDat [DEPTH];
   logic             accept;

   always_comb begin
      take        = '0;
      move        = '0;
      take[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         move[i] = stageVld[i] & take[i+1];
         take[i] = ~stageVld[i] | move[i];
      end
   end

   // reset gates in_ready so nothing is offered while the chain is held cleared
   assign in_ready  = take[0] & ~hold & reset;
   assign out_valid = stageVld[DEPTH-1] & ~hold;
   assign out_data  = stageDat[DEPTH-1];
   assign accept    = in_valid & in_ready;

   always_comb begin
      stageVldNext = stageVld & ~flush_mask;
      if (!hold) begin
         if (move[0]) stageVldNext[0] = 1'b0;
         if (accept)  stageVldNext[0] = 1'b1;
         for (int i = 1; i < DEPTH; i++) begin
            if (move[i])   stageVldNext[i] = 1'b0;
            if (move[i-1]) stageVldNext[i] = ~flush_mask[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stageVld <= '0;
      else        stageVld <= stageVldNext;
   end

   always_ff @(posedge clk) begin
      if (accept) stageDat[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
         if (move[i-1] && !hold) stageDat[i] <= stageDat[i-1];
      end
   end

`ifdef PIPE_STAGE_CHAIN_STATS_EN
   logic [3:0]  occCnt;
   logic [3:0]  killNum;
   logic [15:0] killCnt;
   logic [16:0] killSum;

   // the oldest entry leaving on out_ready is a transfer, not a kill
   always_comb begin
      occCnt  = '0;
      killNum = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (stageVld[i]) occCnt = occCnt + 4'd1;
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (stageVld[i] && flush_mask[i]) killNum = killNum + 4'd1;
      end
      if (stageVld[DEPTH-1] && flush_mask[DEPTH-1] && !(move[DEPTH-1] && !hold))
         killNum = killNum + 4'd1;
      killSum = {1'b0, killCnt} + {13'd0, killNum};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          killCnt <= '0;
      else if (killSum[16]) killCnt <= 16'hFFFF;
      else                  killCnt <= killSum[15:0];
   end

   assign occupancy  = occCnt;
   assign kill_count = killCnt;
`endif

endmodule
